// File: rtl/con_input_fifo.sv
// con_input_fifo: staging FIFO between the three 16-bit connection buses and
// the input/kernel data shifters. One word triplet is captured per
// con_valid/con_ready handshake and presented downstream first-word
// fall-through with a valid/ready handshake, so shifter stalls never lose
// external data. Capture is blocked while the chip itself drives the buses.
//
// Optional statistics counters are compiled in with CON_FIFO_STATS_EN;
// without that macro stall_cycles and accepted are tied to zero.
module con_input_fifo #(
    parameter int IO_DATA_WIDTH = 16,
    parameter int DEPTH         = 4,
    parameter int CNT_WIDTH     = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     arst_in,
    input  logic [IO_DATA_WIDTH-1:0] con_1_in,
    input  logic [IO_DATA_WIDTH-1:0] con_2_in,
    input  logic [IO_DATA_WIDTH-1:0] con_3_in,
    input  logic                     con_valid,
    output logic                     con_ready,
    input  logic                     driving_cons,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [IO_DATA_WIDTH-1:0] out_row_1,
    output logic [IO_DATA_WIDTH-1:0] out_row_2,
    output logic [IO_DATA_WIDTH-1:0] out_row_3,
    output logic [CNT_WIDTH-1:0]     count,
    output logic [31:0]              stall_cycles,
    output logic [31:0]              accepted
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int ROW_W = 3 * IO_DATA_WIDTH;

    localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [PTR_W-1:0]     PTR_ZERO = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0]     PTR_ONE  = PTR_W'(1);
    localparam logic [ROW_W-1:0]     ROW_ZERO = {ROW_W{1'b0}};

    // Storage holds triplets packed as {word1, word2, word3}; it is not reset.
    logic [ROW_W-1:0]     mem_q [DEPTH];
    logic [ROW_W-1:0]     mem_d [DEPTH];

    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0] count_q,  count_d;

    logic                 con_ready_s;
    logic                 wr_en_s;
    logic                 rd_en_s;
    logic                 not_empty_s;
    logic [ROW_W-1:0]     wr_word_s;
    logic [ROW_W-1:0]     head_s;

    // Handshake qualifiers; con_ready depends only on registered count and
    // the two blocking inputs, never on con_valid or out_ready.
    always_comb begin
        not_empty_s = (count_q != CNT_ZERO);
        con_ready_s = (count_q != CNT_FULL) && !driving_cons && !flush;
        wr_en_s     = con_valid && con_ready_s;
        rd_en_s     = not_empty_s && out_ready;
        wr_word_s   = {con_1_in, con_2_in, con_3_in};
    end

    // Next-state for the storage array: only the slot at wr_ptr changes.
    always_comb begin
        mem_d = mem_q;
        if (wr_en_s) begin
            mem_d[wr_ptr_q] = wr_word_s;
        end else begin
            mem_d = mem_q;
        end
    end

    // Storage register update (intentionally without reset).
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Next-state for pointers and occupancy; flush overrides read and write.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = PTR_ZERO;
            rd_ptr_d = PTR_ZERO;
            count_d  = CNT_ZERO;
        end else begin
            if (wr_en_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (rd_en_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({wr_en_s, rd_en_s})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers with asynchronous reset.
    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            wr_ptr_q <= PTR_ZERO;
            rd_ptr_q <= PTR_ZERO;
            count_q  <= CNT_ZERO;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Fall-through head: the word at rd_ptr, forced to zero when empty so
    // stale storage never leaks onto the outputs.
    always_comb begin
        if (not_empty_s) begin
            head_s = mem_q[rd_ptr_q];
        end else begin
            head_s = ROW_ZERO;
        end
    end

    assign con_ready = con_ready_s;
    assign out_valid = not_empty_s;
    assign out_row_1 = head_s[ROW_W-1 -: IO_DATA_WIDTH];
    assign out_row_2 = head_s[2*IO_DATA_WIDTH-1 -: IO_DATA_WIDTH];
    assign out_row_3 = head_s[IO_DATA_WIDTH-1 -: IO_DATA_WIDTH];
    assign count     = count_q;

`ifdef CON_FIFO_STATS_EN
    localparam logic [31:0] STAT_MAX  = 32'hFFFF_FFFF;
    localparam logic [31:0] STAT_ZERO = 32'h0000_0000;
    localparam logic [31:0] STAT_ONE  = 32'h0000_0001;

    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] accepted_q,     accepted_d;

    // Saturating statistics: stalls while the source waits, and accepted writes.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        accepted_d     = accepted_q;
        if (flush) begin
            stall_cycles_d = STAT_ZERO;
            accepted_d     = STAT_ZERO;
        end else begin
            if (con_valid && !con_ready_s && (stall_cycles_q != STAT_MAX)) begin
                stall_cycles_d = stall_cycles_q + STAT_ONE;
            end else begin
                stall_cycles_d = stall_cycles_q;
            end
            if (wr_en_s && (accepted_q != STAT_MAX)) begin
                accepted_d = accepted_q + STAT_ONE;
            end else begin
                accepted_d = accepted_q;
            end
        end
    end

    // Statistics registers with asynchronous reset.
    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            stall_cycles_q <= STAT_ZERO;
            accepted_q     <= STAT_ZERO;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            accepted_q     <= accepted_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign accepted     = accepted_q;
`else
    assign stall_cycles = 32'd0;
    assign accepted     = 32'd0;
`endif

endmodule

// File: tb/tb_con_input_fifo.sv
// Scoreboard bench for con_input_fifo: directed vectors push the triplets
// they expect to be accepted into a queue; a monitor on the falling edge
// pops and compares whenever the DUT hands a triplet downstream, and also
// compares occupancy and out_valid against the queue depth.
module tb_con_input_fifo;

    logic        clk = 1'b0;
    logic        arst_in;
    logic [15:0] con_1_in, con_2_in, con_3_in;
    logic        con_valid;
    logic        con_ready;
    logic        driving_cons;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_row_1, out_row_2, out_row_3;
    logic [2:0]  count;
    logic [31:0] stall_cycles;
    logic [31:0] accepted;

    int total = 0;
    int bad   = 0;
    logic [47:0] exp_q[$];

`ifdef CON_FIFO_STATS_EN
    localparam logic [31:0] EXP_STALL = 32'd5;
    localparam logic [31:0] EXP_ACC   = 32'd6;
`else
    localparam logic [31:0] EXP_STALL = 32'd0;
    localparam logic [31:0] EXP_ACC   = 32'd0;
`endif

    con_input_fifo dut (
        .clk          (clk),
        .arst_in      (arst_in),
        .con_1_in     (con_1_in),
        .con_2_in     (con_2_in),
        .con_3_in     (con_3_in),
        .con_valid    (con_valid),
        .con_ready    (con_ready),
        .driving_cons (driving_cons),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_row_1    (out_row_1),
        .out_row_2    (out_row_2),
        .out_row_3    (out_row_3),
        .count        (count),
        .stall_cycles (stall_cycles),
        .accepted     (accepted)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: occupancy model and in-order delivery of accepted triplets.
    always @(negedge clk) begin
        logic [47:0] e;
        if (!arst_in) begin
            check("occupancy", 32'(count), 32'(exp_q.size()));
            check("out_valid", 32'(out_valid), (exp_q.size() != 0) ? 32'd1 : 32'd0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL pop_unexpected: got %0h_%0h_%0h expected none",
                             out_row_1, out_row_2, out_row_3);
                end else begin
                    e = exp_q.pop_front();
                    check("row_1", 32'(out_row_1), 32'(e[47:32]));
                    check("row_2", 32'(out_row_2), 32'(e[31:16]));
                    check("row_3", 32'(out_row_3), 32'(e[15:0]));
                end
            end
        end
    end

    // One clock of stimulus; called at posedge+2, returns at posedge+2.
    task automatic cycle(input logic v, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] c, input logic rdy, input logic exp_rdy,
                         input string nm);
        con_valid = v;
        con_1_in  = a;
        con_2_in  = b;
        con_3_in  = c;
        out_ready = rdy;
        @(negedge clk);
        check(nm, 32'(con_ready), 32'(exp_rdy));
        @(posedge clk);
        #1;
        if (v && exp_rdy) exp_q.push_back({a, b, c});
        con_valid = 1'b0;
        out_ready = 1'b0;
        #1;
    endtask

    task automatic fill4(input logic [15:0] base);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 16'(base + 16'(3*i)), 16'(base + 16'(3*i + 1)),
                  16'(base + 16'(3*i + 2)), 1'b0, 1'b1, "fill_ready");
        end
    endtask

    initial begin
        arst_in      = 1'b1;
        con_1_in     = 16'h0000;
        con_2_in     = 16'h0000;
        con_3_in     = 16'h0000;
        con_valid    = 1'b0;
        driving_cons = 1'b0;
        flush        = 1'b0;
        out_ready    = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_count", 32'(count), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_row_1", 32'(out_row_1), 32'd0);
        check("rst_row_3", 32'(out_row_3), 32'd0);
        check("rst_con_ready", 32'(con_ready), 32'd1);
        check("rst_stall", stall_cycles, 32'd0);
        check("rst_accepted", accepted, 32'd0);
        @(posedge clk);
        #1;
        arst_in = 1'b0;
        #1;

        // Fill then drain in order
        fill4(16'd1);
        check("full_count", 32'(count), 32'd4);
        check("full_con_ready", 32'(con_ready), 32'd0);
        cycle(1'b0, 16'h0, 16'h0, 16'h0, 1'b1, 1'b0, "drain_ready_0");
        cycle(1'b0, 16'h0, 16'h0, 16'h0, 1'b1, 1'b1, "drain_ready_1");
        cycle(1'b0, 16'h0, 16'h0, 16'h0, 1'b1, 1'b1, "drain_ready_2");
        cycle(1'b0, 16'h0, 16'h0, 16'h0, 1'b1, 1'b1, "drain_ready_3");
        check("drained_count", 32'(count), 32'd0);
        check("drained_valid", 32'(out_valid), 32'd0);

        // One-cycle fall-through latency
        cycle(1'b1, 16'hAAAA, 16'hBBBB, 16'hCCCC, 1'b0, 1'b1, "lat_wr");
        @(negedge clk);
        check("lat_valid", 32'(out_valid), 32'd1);
        check("lat_row_1", 32'(out_row_1), 32'h0000_AAAA);
        check("lat_row_2", 32'(out_row_2), 32'h0000_BBBB);
        check("lat_row_3", 32'(out_row_3), 32'h0000_CCCC);
        @(posedge clk);
        #2;
        cycle(1'b0, 16'h0, 16'h0, 16'h0, 1'b1, 1'b1, "lat_drain");

        // Streaming at count=2 with pointer wrap
        cycle(1'b1, 16'h0101, 16'h0102, 16'h0103, 1'b0, 1'b1, "stream_pre");
        cycle(1'b1, 16'h0201, 16'h0202, 16'h0203, 1'b0, 1'b1, "stream_pre");
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 16'(16'h1000 + 16'(i)), 16'(16'h2000 + 16'(i)),
                  16'(16'h3000 + 16'(i)), 1'b1, 1'b1, "stream_ready");
            check("stream_count", 32'(count), 32'd2);
        end
        cycle(1'b0, 16'h0, 16'h0, 16'h0, 1'b1, 1'b1, "stream_drain");
        cycle(1'b0, 16'h0, 16'h0, 16'h0, 1'b1, 1'b1, "stream_drain");

        // Full plus read: blocked write, then accepted write next cycle
        fill4(16'h3001);
        cycle(1'b1, 16'h3F01, 16'h3F02, 16'h3F03, 1'b1, 1'b0, "fullrd_blocked");
        check("fullrd_count_a", 32'(count), 32'd3);
        cycle(1'b1, 16'h3E01, 16'h3E02, 16'h3E03, 1'b1, 1'b1, "fullrd_accept");
        check("fullrd_count_b", 32'(count), 32'd3);
        for (int i = 0; i < 3; i++) cycle(1'b0, 16'h0, 16'h0, 16'h0, 1'b1, 1'b1, "fullrd_drain");

        // driving_cons blocks capture
        cycle(1'b1, 16'h5001, 16'h5002, 16'h5003, 1'b0, 1'b1, "drv_pre");
        cycle(1'b1, 16'h5011, 16'h5012, 16'h5013, 1'b0, 1'b1, "drv_pre");
        driving_cons = 1'b1;
        cycle(1'b1, 16'hDEAD, 16'hDEAD, 16'hDEAD, 1'b0, 1'b0, "drv_block");
        check("drv_count", 32'(count), 32'd2);
        driving_cons = 1'b0;
        cycle(1'b1, 16'h5021, 16'h5022, 16'h5023, 1'b0, 1'b1, "drv_resume");
        check("drv_resume_count", 32'(count), 32'd3);

        // Flush with concurrent write attempt
        flush = 1'b1;
        cycle(1'b1, 16'hBEEF, 16'hBEEF, 16'hBEEF, 1'b0, 1'b0, "flush_block");
        exp_q.delete();
        flush = 1'b0;
        check("flush_count", 32'(count), 32'd0);
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_stall", stall_cycles, 32'd0);
        check("flush_accepted", accepted, 32'd0);

        // Statistics: 4 fills, 5 stalls while full, drain 2, write 2
        fill4(16'h6101);
        for (int i = 0; i < 5; i++) cycle(1'b1, 16'h7777, 16'h7777, 16'h7777, 1'b0, 1'b0, "stat_stall");
        cycle(1'b0, 16'h0, 16'h0, 16'h0, 1'b1, 1'b0, "stat_drain_0");
        cycle(1'b0, 16'h0, 16'h0, 16'h0, 1'b1, 1'b1, "stat_drain_1");
        cycle(1'b1, 16'h6201, 16'h6202, 16'h6203, 1'b0, 1'b1, "stat_wr");
        cycle(1'b1, 16'h6211, 16'h6212, 16'h6213, 1'b0, 1'b1, "stat_wr");
        check("stat_stall_cycles", stall_cycles, EXP_STALL);
        check("stat_accepted", accepted, EXP_ACC);
        cycle(1'b0, 16'h0, 16'h0, 16'h0, 1'b1, 1'b0, "stat_end_drain_0");
        for (int i = 0; i < 3; i++) cycle(1'b0, 16'h0, 16'h0, 16'h0, 1'b1, 1'b1, "stat_end_drain");

        // Asynchronous reset mid-operation
        cycle(1'b1, 16'h8001, 16'h8002, 16'h8003, 1'b0, 1'b1, "arst_pre");
        cycle(1'b1, 16'h8011, 16'h8012, 16'h8013, 1'b0, 1'b1, "arst_pre");
        #1;
        arst_in = 1'b1;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_count", 32'(count), 32'd0);
        check("arst_row_1", 32'(out_row_1), 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        arst_in = 1'b0;
        #1;
        cycle(1'b1, 16'h9001, 16'h9002, 16'h9003, 1'b0, 1'b1, "post_arst_wr");
        cycle(1'b0, 16'h0, 16'h0, 16'h0, 1'b1, 1'b1, "post_arst_drain");

        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        check("final_count", 32'(count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
